counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter W, default 3, SHALL set the width of the controlled counter and of each operand.
REQ-002 Parameter NREQ, default 2, SHALL set the number of requesters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL be the per-requester operation request.
REQ-006 req_load  input  NREQ  SHALL select the op per requester: 1 = load, 0 = step.
REQ-007 req_val  input  NREQ*W  SHALL carry the load value or step count; requester i uses slice [i*W +: W].
REQ-008 gnt  output  NREQ  SHALL be the one-hot grant, held for the whole operation.
REQ-009 done  output  NREQ  SHALL pulse one cycle on the granted bit at completion.
REQ-010 err  output  1  SHALL pulse with done when the counter result mismatches the expected value.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 ctr_ld, ctr_inc  output  1 each  SHALL drive the counter load and increment strobes.
REQ-013 ctr_data_in  output  W  SHALL drive the counter load value.
REQ-014 ctr_data_out  input  W  SHALL be the counter's registered output (ld/inc at cycle t visible at t+1).

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, STEP and DONE.
REQ-016 In IDLE with any req high at cycle t, the controller SHALL accept one requester by round-robin, starting after the last granted index.
REQ-017 At acceptance it SHALL latch op, value, index and the current ctr_data_out as the start value.
REQ-018 gnt[idx] SHALL be high from t+1 through the DONE cycle inclusive.
REQ-019 Load op: LOAD at t+1 with ctr_ld=1 and ctr_data_in=value; DONE at t+2.
REQ-020 Step op with count N>0: STEP for cycles t+1..t+N with ctr_inc=1; DONE at t+N+1.
REQ-021 Step op with N=0: DONE at t+1, no strobe.
REQ-022 ctr_ld and ctr_inc SHALL never be high together; both SHALL be 0 outside LOAD/STEP; ctr_data_in SHALL be 0 outside LOAD.
REQ-023 Expected result SHALL be the load value, or (start + N) mod 2^W; wrap-around is legal.
REQ-024 In DONE: done[idx]=1; err=1 iff ctr_data_out != expected; next state IDLE.
REQ-025 req changes after acceptance SHALL be ignored; a req still high in IDLE after DONE SHALL count as a new request.
REQ-026 With simultaneous requests held continuously, grants SHALL rotate; no requester waits more than NREQ operations.
REQ-027 Consecutive operations SHALL be separated by exactly one IDLE cycle.

Reset
REQ-028 While rst=0, all outputs SHALL be 0, the state SHALL be IDLE and the round-robin pointer SHALL give requester 0 highest priority, regardless of clk.
REQ-029 Reset during LOAD or STEP SHALL abort the operation; no done or err SHALL be issued for it.

Structure
REQ-030 The state encodings and the default W SHALL be defined in the shared package counter_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (req, advance, one-hot grant, pointer register).
REQ-032 The step counter SHALL be W bits wide.

Verification
REQ-033 Reset: rst=0 mid-run -> all outputs 0 immediately; after release, a req[1] and req[0] pair is granted to 0 first.
REQ-034 Load: req[0], load, val=5 at t -> ctr_ld at t+1 with data_in=5; done[0] at t+2; data_out=5; err=0.
REQ-035 Step with wrap: counter=6, req[1] step N=3 -> ctr_inc at t+1..t+3; done[1] at t+4; data_out=1; err=0.
REQ-036 Zero step: N=0 -> done at t+1; no ctr_inc; err=0.
REQ-037 Fairness: req[0] and req[1] held high with step N=1 -> gnt order 0,1,0,1; one IDLE cycle between operations.
REQ-038 Fault: counter model ignores inc, step N=2 -> err=1 in the same cycle as done.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller: default operand
// width, FSM state encodings and an index-width helper.
package counter_pkg;

    // Default width of the controlled counter and of each operand.
    localparam int unsigned W_DEFAULT = 3;

    // Controller state encodings, kept as fixed constants so the encoding
    // stays identical to the legacy implementation.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request starting at the
// priority pointer, and moves the pointer past the winner on advance.
module rr_arbiter
    import counter_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    input  logic                           advance,
    output logic [NREQ-1:0]                grant,
    output logic [idx_width(NREQ)-1:0]     grant_idx
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [IW-1:0] ptr;
    logic          found;
    int unsigned   pos;

    // Scan requesters in rotating order starting at the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req[pos]) begin
                found       = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = IW'(pos);
            end
        end
    end

    // Priority pointer: requester 0 first after reset, then the one after the last winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            if (32'(grant_idx) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external counter: arbitrates requesters,
// performs a load or an N-step increment, then verifies the counter result.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned W    = W_DEFAULT,
    parameter int unsigned NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_load,
    input  logic [NREQ*W-1:0]   req_val,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic                busy,
    output logic                ctr_ld,
    output logic                ctr_inc,
    output logic [W-1:0]        ctr_data_in,
    input  logic [W-1:0]        ctr_data_out
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [1:0]      state;
    logic [1:0]      state_nxt;

    logic            op_load;
    logic [W-1:0]    op_val;
    logic [W-1:0]    start_val;
    logic [W-1:0]    step_cnt;
    logic [IW-1:0]   op_idx;
    logic [W-1:0]    expected;
    logic [NREQ-1:0] op_onehot;

    logic            accept;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            sel_load;
    logic [W-1:0]    sel_val;

    assign accept = (state == S_IDLE) && (|req);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // One-hot grant selects the winner's op and operand.
    always_comb begin
        sel_load = 1'b0;
        sel_val  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_load = req_load[i];
                sel_val  = req_val[i*W +: W];
            end
        end
    end

    // Next-state logic; a zero step count skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (sel_load) begin
                        state_nxt = S_LOAD;
                    end else if (sel_val == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_LOAD:  state_nxt = S_DONE;
            S_STEP: begin
                if (step_cnt == W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and operation registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_load   <= 1'b0;
            op_val    <= '0;
            start_val <= '0;
            step_cnt  <= '0;
            op_idx    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_load   <= sel_load;
                op_val    <= sel_val;
                start_val <= ctr_data_out;
                step_cnt  <= sel_val;
                op_idx    <= arb_idx;
            end else if (state == S_STEP) begin
                step_cnt <= step_cnt - 1'b1;
            end
        end
    end

    // Result the counter must hold in DONE; step results wrap modulo 2^W.
    always_comb begin
        expected = op_load ? op_val : (start_val + op_val);
    end

    // Decode the latched requester index.
    always_comb begin
        op_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_onehot[i] = (op_idx == IW'(i));
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        busy        = (state != S_IDLE);
        ctr_ld      = (state == S_LOAD);
        ctr_inc     = (state == S_STEP);
        ctr_data_in = (state == S_LOAD) ? op_val : '0;
        gnt         = busy ? op_onehot : '0;
        done        = (state == S_DONE) ? op_onehot : '0;
        err         = (state == S_DONE) && (ctr_data_out != expected);
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl with a behavioural counter model.
module tb_counter_seq_ctrl;

    localparam int W    = 3;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_load;
    logic [NREQ*W-1:0] req_val;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic              ctr_ld;
    logic              ctr_inc;
    logic [W-1:0]      ctr_data_in;
    logic [W-1:0]      ctr_data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic         err;
        int           cyc;
        int           n_inc;
        int           n_ld;
    } exp_t;

    exp_t sb[$];

    counter_seq_ctrl #(
        .W    (W),
        .NREQ (NREQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_load     (req_load),
        .req_val      (req_val),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .ctr_ld       (ctr_ld),
        .ctr_inc      (ctr_inc),
        .ctr_data_in  (ctr_data_in),
        .ctr_data_out (ctr_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Counter model; ignore_inc plants a counter that drops increments.
    logic [W-1:0] ctr;
    bit           ignore_inc = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) ctr <= '0;
        else if (ctr_ld) ctr <= ctr_data_in;
        else if (ctr_inc && !ignore_inc) ctr <= ctr + 1'b1;
    end
    assign ctr_data_out = ctr;

    // Monitor: count strobes per operation, pop and compare on done.
    int   m_inc = 0;
    int   m_ld  = 0;
    bit   m_bad = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        if ((ctr_ld && ctr_inc) || (!ctr_ld && ctr_data_in != '0) ||
            (!busy && (ctr_ld || ctr_inc)) || (err && done == '0))
            m_bad = 1'b1;
        if (!busy) begin
            m_inc = 0;
            m_ld  = 0;
        end else begin
            m_inc += int'(ctr_inc);
            m_ld  += int'(ctr_ld);
        end
        if (done != '0) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("done",  32'(done),         32'(1) << m_e.idx);
                check("gnt",   32'(gnt),          32'(1) << m_e.idx);
                check("err",   32'(err),          32'(m_e.err));
                check("data",  32'(ctr_data_out), 32'(m_e.data));
                check("lat",   cyc,               m_e.cyc);
                check("n_inc", m_inc,             m_e.n_inc);
                check("n_ld",  m_ld,              m_e.n_ld);
            end
        end
    end

    int ptr_m = 0;

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic push_op(input int idx, input bit ld, input int v, input int t,
                           input logic [W-1:0] start);
        exp_t e;
        e.idx   = idx;
        e.data  = ld ? W'(v) : (ignore_inc ? start : W'(int'(start) + v));
        e.err   = ld ? 1'b0 : (ignore_inc && v != 0);
        e.cyc   = t + (ld ? 2 : (v == 0 ? 1 : v + 1));
        e.n_inc = ld ? 0 : v;
        e.n_ld  = ld ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic single_op(input int idx, input bit ld, input int v);
        wait_idle();
        req = '0; req_load = '0; req_val = '0;
        req[idx]             = 1'b1;
        req_load[idx]        = ld;
        req_val[idx*W +: W]  = W'(v);
        push_op(idx, ld, v, cyc, ctr);
        ptr_m = (idx + 1) % NREQ;
        @(negedge clk);
        req = '0; req_load = '0; req_val = '0;
        if (ld) begin
            check("ld_strobe", 32'(ctr_ld), 1);
            check("ld_data",   32'(ctr_data_in), 32'(v % 8));
            check("ld_noinc",  32'(ctr_inc), 0);
        end
    endtask

    // Both requesters held with the same step count; grants must alternate.
    task automatic pair_ops(input int n_ops, input int v);
        int t0;
        int t_last;
        int k;
        logic [W-1:0] start;
        wait_idle();
        t0    = cyc;
        start = ctr;
        req      = '1;
        req_load = '0;
        req_val  = {W'(v), W'(v)};
        for (k = 0; k < n_ops; k++)
            push_op((ptr_m + k) % NREQ, 1'b0, v, t0 + k * (v + 2), W'(int'(start) + k * v));
        t_last = t0 + (n_ops - 1) * (v + 2);
        ptr_m  = (ptr_m + n_ops) % NREQ;
        k = 0;
        while (cyc < t_last + v + 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        req = '0; req_val = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; req_load = '0; req_val = '0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt",  32'(gnt),  0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        single_op(0, 1'b1, 5);           // load 5
        single_op(1, 1'b1, 6);           // counter = 6
        single_op(1, 1'b0, 3);           // 6+3 wraps to 1
        single_op(0, 1'b0, 0);           // zero step
        single_op(0, 1'b0, 7);           // 1+7 wraps to 0
        pair_ops(4, 1);                  // fairness 0,1,0,1

        ignore_inc = 1'b1;
        single_op(1, 1'b0, 2);           // counter drops incs -> err
        wait_idle();
        ignore_inc = 1'b0;

        for (int i = 0; i < 6; i++)
            single_op(int'($urandom_range(0, 1)), 1'(($urandom_range(0, 1))), int'($urandom_range(0, 7)));

        // Abort a step op on requester 0 with reset, then check pointer reset.
        wait_idle();
        req[0] = 1'b1; req_load = '0; req_val = '0; req_val[0 +: W] = W'(5);
        @(negedge clk);
        req = '0; req_val = '0;
        @(negedge clk);
        check("pre_rst_inc", 32'(ctr_inc), 1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy),        0);
        check("abort_gnt",  32'(gnt),         0);
        check("abort_inc",  32'(ctr_inc),     0);
        check("abort_ld",   32'(ctr_ld),      0);
        check("abort_din",  32'(ctr_data_in), 0);
        check("abort_done", 32'(done),        0);
        check("abort_err",  32'(err),         0);
        ptr_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pair_ops(2, 1);                  // requester 0 must win first

        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_left",      sb.size(), 0);
        check("strobe_rules", 32'(m_bad), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
